// File: rtl/riscv_lsu_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
interface riscv_lsu_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    modport master (
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        input  mem_rd_i, mem_ready_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        output mem_rd_i, mem_ready_i
    );
endinterface

// File: rtl/riscv_lsu.sv
// Load/store unit: one memory access per request, lane steering and load extension.
// Optional macro LSU_MISALIGN_CHECK_EN rejects misaligned H/W accesses without a bus cycle.
module riscv_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_req_o,
    output logic        core_err_o,
    riscv_lsu_if.master mem
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [7:0] TimeoutMax = 8'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rd_q, rd_d;

    logic        size_legal;
    logic        misaligned;
    logic        busy;
    logic [3:0]  be_c;
    logic [31:0] wd_c;
    logic [31:0] rd_shift;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

    assign size_legal = (core_size_i == 3'd0) || (core_size_i == 3'd1) ||
                        (core_size_i == 3'd2) || (core_size_i == 3'd4) ||
                        (core_size_i == 3'd5);

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = ((core_size_i[1:0] == 2'd1) && core_addr_i[0]) ||
                        ((core_size_i[1:0] == 2'd2) && (core_addr_i[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        be_c = 4'b1111;
        wd_c = wd_q;
        if (we_q) begin
            unique case (size_q[1:0])
                2'd0: begin
                    be_c = 4'b0001 << addr_q[1:0];
                    wd_c = {4{wd_q[7:0]}};
                end
                2'd1: begin
                    be_c = addr_q[1] ? 4'b1100 : 4'b0011;
                    wd_c = {2{wd_q[15:0]}};
                end
                default: begin
                    be_c = 4'b1111;
                    wd_c = wd_q;
                end
            endcase
        end
    end

    // Byte lane is brought down to bits [7:0]; half lane picked by addr[1].
    assign rd_shift = mem.mem_rd_i >> {addr_q[1:0], 3'b000};
    assign rd_half  = addr_q[1] ? mem.mem_rd_i[31:16] : mem.mem_rd_i[15:0];

    always_comb begin
        unique case (size_q)
            3'd0:    load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd1:    load_ext = {{16{rd_half[15]}}, rd_half};
            3'd4:    load_ext = {24'd0, rd_shift[7:0]};
            3'd5:    load_ext = {16'd0, rd_half};
            default: load_ext = mem.mem_rd_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        unique case (state_q)
            StIdle: begin
                if (core_req_i) begin
                    if (!size_legal || misaligned) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        we_d    = core_we_i;
                        size_d  = core_size_i;
                        addr_d  = core_addr_i;
                        wd_d    = core_wd_i;
                        cnt_d   = 8'd0;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (mem.mem_ready_i) begin
                    if (!we_q) begin
                        rd_d = load_ext;
                    end
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == TimeoutMax) begin
                        rd_d    = 32'd0;
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                cnt_d   = 8'd0;
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= 32'd0;
            wd_q    <= 32'd0;
            rd_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
        end
    end

    assign busy = (state_q == StBusy);

    assign mem.mem_req_o  = busy;
    assign mem.mem_we_o   = busy & we_q;
    assign mem.mem_be_o   = busy ? be_c : 4'b0000;
    assign mem.mem_addr_o = busy ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem.mem_wd_o   = (busy && we_q) ? wd_c : 32'd0;

    assign core_rd_o  = rd_q;
    assign core_err_o = (state_q == StDone) & err_q;
    // Reset gating keeps the PC released while reset is held.
    assign core_stall_req_o = core_req_i & (state_q != StDone) & ~rst_i;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed self-checking bench for riscv_lsu (built with TIMEOUT_CYCLES=4).
module tb_riscv_lsu;

    logic        clk;
    logic        rst;
    logic        core_req;
    logic        core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr;
    logic [31:0] core_wd;
    logic [31:0] core_rd;
    logic        core_stall;
    logic        core_err;

    int errors;
    int checks;

    riscv_lsu_if bus ();

    riscv_lsu #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .core_req_i      (core_req),
        .core_we_i       (core_we),
        .core_size_i     (core_size),
        .core_addr_i     (core_addr),
        .core_wd_i       (core_wd),
        .core_rd_o       (core_rd),
        .core_stall_req_o(core_stall),
        .core_err_o      (core_err),
        .mem             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wd);
        core_req  = 1'b1;
        core_we   = we;
        core_size = size;
        core_addr = addr;
        core_wd   = wd;
    endtask

    task automatic release_req();
        core_req = 1'b0;
        tick();
    endtask

    // Load with ready on the first BUSY cycle; returns in the DONE cycle.
    task automatic load_once(input logic [2:0] size, input logic [31:0] addr,
                             input logic [31:0] rdata);
        drive(1'b0, size, addr, 32'd0);
        bus.mem_rd_i    = rdata;
        bus.mem_ready_i = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        checks++;
        if (bus.mem_req_o !== 1'b0 || core_stall !== 1'b0 || core_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req=%b stall=%b err=%b, want 0 0 0",
                     bus.mem_req_o, core_stall, core_err);
        end
        checks++;
        if (core_rd !== 32'd0 || bus.mem_be_o !== 4'd0 || bus.mem_addr_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: rd=%h be=%b addr=%h, want 0", core_rd, bus.mem_be_o,
                     bus.mem_addr_o);
        end
    endtask

    task automatic test_store_word();
        int stall_cycles;
        stall_cycles = 0;
        drive(1'b1, 3'd2, 32'h0000_0104, 32'hDEAD_BEEF);
        bus.mem_ready_i = 1'b1;
        #1;
        if (core_stall === 1'b1) stall_cycles++;
        tick();
        if (core_stall === 1'b1) stall_cycles++;
        checks++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b1 || bus.mem_be_o !== 4'b1111 ||
            bus.mem_addr_o !== 32'h0000_0104 || bus.mem_wd_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL sw_bus: req=%b we=%b be=%b addr=%h wd=%h, want 1 1 1111 00000104 deadbeef",
                     bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wd_o);
        end
        tick();
        checks++;
        if (core_stall !== 1'b0 || bus.mem_req_o !== 1'b0 || core_err !== 1'b0) begin
            errors++;
            $display("FAIL sw_done: stall=%b req=%b err=%b, want 0 0 0", core_stall,
                     bus.mem_req_o, core_err);
        end
        checks++;
        if (stall_cycles != 2) begin
            errors++;
            $display("FAIL sw_stall_cycles: got %0d, want 2", stall_cycles);
        end
        release_req();
    endtask

    task automatic test_loads();
        load_once(3'd0, 32'h0000_0203, 32'h8011_2233);
        checks++;
        if (core_rd !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb: rd=%h, want ffffff80", core_rd);
        end
        release_req();
        checks++;
        if (core_rd !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb_hold: rd=%h, want ffffff80", core_rd);
        end
        load_once(3'd4, 32'h0000_0203, 32'h8011_2233);
        checks++;
        if (core_rd !== 32'h0000_0080) begin
            errors++;
            $display("FAIL lbu: rd=%h, want 00000080", core_rd);
        end
        release_req();
        load_once(3'd5, 32'h0000_0202, 32'hBEEF_1234);
        checks++;
        if (core_rd !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL lhu: rd=%h, want 0000beef", core_rd);
        end
        release_req();
    endtask

    task automatic test_store_lanes();
        drive(1'b1, 3'd1, 32'h0000_0202, 32'h0000_ABCD);
        bus.mem_ready_i = 1'b1;
        tick();
        checks++;
        if (bus.mem_be_o !== 4'b1100 || bus.mem_wd_o !== 32'hABCD_ABCD ||
            bus.mem_addr_o !== 32'h0000_0200) begin
            errors++;
            $display("FAIL sh: be=%b wd=%h addr=%h, want 1100 abcdabcd 00000200",
                     bus.mem_be_o, bus.mem_wd_o, bus.mem_addr_o);
        end
        tick();
        release_req();
        drive(1'b1, 3'd0, 32'h0000_0001, 32'h1234_565A);
        tick();
        checks++;
        if (bus.mem_be_o !== 4'b0010 || bus.mem_wd_o !== 32'h5A5A_5A5A) begin
            errors++;
            $display("FAIL sb: be=%b wd=%h, want 0010 5a5a5a5a", bus.mem_be_o, bus.mem_wd_o);
        end
        tick();
        release_req();
        checks++;
        if (core_rd !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL store_keeps_rd: rd=%h, want 0000beef", core_rd);
        end
    endtask

    task automatic test_timeout();
        int req_cycles;
        req_cycles = 0;
        drive(1'b0, 3'd2, 32'h0000_0300, 32'd0);
        bus.mem_ready_i = 1'b0;
        tick();
        while (bus.mem_req_o === 1'b1 && req_cycles < 20) begin
            req_cycles++;
            tick();
        end
        checks++;
        if (req_cycles != 4) begin
            errors++;
            $display("FAIL timeout_req_cycles: got %0d, want 4", req_cycles);
        end
        checks++;
        if (core_err !== 1'b1 || core_rd !== 32'd0 || core_stall !== 1'b0) begin
            errors++;
            $display("FAIL timeout_done: err=%b rd=%h stall=%b, want 1 00000000 0",
                     core_err, core_rd, core_stall);
        end
        release_req();
        checks++;
        if (core_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err_pulse: err=%b, want 0", core_err);
        end
    endtask

    task automatic test_reset_mid_busy();
        drive(1'b0, 3'd2, 32'h0000_0400, 32'd0);
        bus.mem_ready_i = 1'b0;
        tick();
        checks++;
        if (bus.mem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_busy: req=%b, want 1", bus.mem_req_o);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.mem_req_o !== 1'b0 || core_stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: req=%b stall=%b, want 0 0", bus.mem_req_o, core_stall);
        end
        tick();
        rst = 1'b0;
        bus.mem_rd_i    = 32'h1234_5678;
        bus.mem_ready_i = 1'b1;
        tick();
        checks++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h0000_0400) begin
            errors++;
            $display("FAIL rst_new_lw_bus: req=%b addr=%h, want 1 00000400", bus.mem_req_o,
                     bus.mem_addr_o);
        end
        tick();
        checks++;
        if (core_rd !== 32'h1234_5678 || core_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_new_lw: rd=%h err=%b, want 12345678 0", core_rd, core_err);
        end
        release_req();
    endtask

    task automatic test_misalign();
        drive(1'b0, 3'd2, 32'h0000_0102, 32'd0);
        bus.mem_rd_i    = 32'hCAFE_F00D;
        bus.mem_ready_i = 1'b1;
        tick();
`ifdef LSU_MISALIGN_CHECK_EN
        checks++;
        if (bus.mem_req_o !== 1'b0 || core_err !== 1'b1 || core_stall !== 1'b0 ||
            core_rd !== 32'h1234_5678) begin
            errors++;
            $display("FAIL misalign_err: req=%b err=%b stall=%b rd=%h, want 0 1 0 12345678",
                     bus.mem_req_o, core_err, core_stall, core_rd);
        end
`else
        checks++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h0000_0100) begin
            errors++;
            $display("FAIL misalign_bus: req=%b addr=%h, want 1 00000100", bus.mem_req_o,
                     bus.mem_addr_o);
        end
        tick();
        checks++;
        if (core_rd !== 32'hCAFE_F00D || core_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_done: rd=%h err=%b, want cafef00d 0", core_rd, core_err);
        end
`endif
        release_req();
    endtask

    task automatic test_illegal_size();
        drive(1'b0, 3'd3, 32'h0000_0010, 32'd0);
        bus.mem_ready_i = 1'b1;
        tick();
        checks++;
        if (bus.mem_req_o !== 1'b0 || core_err !== 1'b1 || core_stall !== 1'b0) begin
            errors++;
            $display("FAIL illegal_size: req=%b err=%b stall=%b, want 0 1 0", bus.mem_req_o,
                     core_err, core_stall);
        end
        release_req();
    endtask

    task automatic test_back_to_back();
        load_once(3'd0, 32'h0000_0001, 32'h0000_FF00);
        checks++;
        if (core_rd !== 32'hFFFF_FFFF || core_stall !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: rd=%h stall=%b, want ffffffff 0", core_rd, core_stall);
        end
        drive(1'b0, 3'd1, 32'h0000_0000, 32'd0);
        bus.mem_rd_i = 32'h0000_8001;
        tick();
        checks++;
        if (core_stall !== 1'b1 || bus.mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: stall=%b req=%b, want 1 0", core_stall, bus.mem_req_o);
        end
        tick();
        checks++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_be_o !== 4'b1111) begin
            errors++;
            $display("FAIL b2b_busy: req=%b be=%b, want 1 1111", bus.mem_req_o, bus.mem_be_o);
        end
        tick();
        checks++;
        if (core_rd !== 32'hFFFF_8001) begin
            errors++;
            $display("FAIL b2b_second: rd=%h, want ffff8001", core_rd);
        end
        release_req();
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        rst             = 1'b1;
        core_req        = 1'b0;
        core_we         = 1'b0;
        core_size       = 3'd0;
        core_addr       = 32'd0;
        core_wd         = 32'd0;
        bus.mem_rd_i    = 32'd0;
        bus.mem_ready_i = 1'b0;
        #2;
        test_reset();
        tick();
        rst = 1'b0;
        tick();
        test_store_word();
        test_loads();
        test_store_lanes();
        test_timeout();
        test_reset_mid_busy();
        test_misalign();
        test_illegal_size();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit sitting between the decoder/ALU and the data memory bus.
- Sequences one memory access per load/store instruction.
- Generates byte enables and write-data lane replication, and sign/zero-extends load data.
- Drives core_stall_req_o, which feeds the decoder's lsu_stall_req_i, to hold the PC until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255: maximum BUSY cycles spent waiting for mem_ready_i before the access is aborted with an error. Legal range 1..255 (8-bit counter).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- core_req_i  in  1  load/store request from the decoder (mem_req_o).
- core_we_i  in  1  1 = store, 0 = load (decoder mem_we_o).
- core_size_i  in  3  access size/type: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
- core_addr_i  in  32  byte address from the ALU.
- core_wd_i  in  32  store data (rs2).
- core_rd_o  out  32  extended load data to the register file.
- core_stall_req_o  out  1  stall request to the decoder / PC enable.
- core_err_o  out  1  one-cycle pulse: access aborted.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  4  byte enables.
- mem_addr_o  out  32  word-aligned address.
- mem_wd_o  out  32  lane-replicated write data.
- mem_rd_i  in  32  memory read data, valid with mem_ready_i.
- mem_ready_i  in  1  access complete this cycle.

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0, latched request registers 0.
  - Reset is asynchronous: mem_req_o drops without waiting for a clock edge.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On core_req_i=1 with a legal size: latch we/size/addr/wd and go to BUSY.
  - On core_req_i=1 with an illegal size (3, 6, 7): skip memory, go to DONE with the error flag set.
- BUSY:
  - mem_req_o=1 and all mem_* outputs driven from latched registers, held stable until mem_ready_i is sampled high.
  - On mem_ready_i=1: capture the extended load data into core_rd_o (loads only; stores leave core_rd_o unchanged), go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES without ready: drop the request, set core_rd_o=0, set the error flag, go to DONE.
- DONE:
  - One cycle only. core_err_o equals the error flag. Next state is IDLE; the counter and error flag clear.
- core_stall_req_o = core_req_i & (state != DONE), combinational.
- Latency:
  - Request seen in cycle 0 → mem_req_o in cycle 1.
  - Ready in cycle 1 → DONE in cycle 2, stall low in cycle 2.
  - Minimum of 2 stall cycles per access.
- Back-to-back accesses: the next request is accepted in the IDLE cycle after DONE.
- If core_req_i deasserts while BUSY, the bus access still completes (no cancel); the result is discarded and stall follows core_req_i.
- mem_addr_o = {addr[31:2], 2'b00}.
- Store byte enables and data:
  - B: be = 0001 << addr[1:0], wd = {4{wd[7:0]}}.
  - H: be = 0011 << {addr[1], 0}, wd = {2{wd[15:0]}}.
  - W: be = 1111, wd = wd.
- Loads: mem_be_o = 1111. The byte/half is selected by addr[1:0] / addr[1]:
  - B and H sign-extend.
  - BU and HU zero-extend.
- core_rd_o holds its value until the next load completes.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined:
  - H with addr[0]=1, or W with addr[1:0] != 0, is misaligned.
  - A misaligned access issues no memory request. IDLE goes directly to DONE with core_err_o=1 and core_rd_o unchanged.
  - Stall is high for exactly 1 cycle.
- Undefined:
  - H ignores addr[0]; W ignores addr[1:0].
  - The access proceeds normally with no error.

Test Plan:
- SW addr 0x104, wd 0xDEADBEEF, ready on the first BUSY cycle → mem_be_o=1111, mem_addr_o=0x104, mem_wd_o=0xDEADBEEF; stall high for 2 cycles, then low.
- LB addr 0x203, mem_rd_i=0x80112233 → core_rd_o=0xFFFFFF80. Same transaction as LBU → 0x00000080.
- LHU addr 0x202, mem_rd_i=0xBEEF1234 → core_rd_o=0x0000BEEF. SH addr 0x202, wd 0x0000ABCD → be=1100, wd=0xABCDABCD.
- TIMEOUT_CYCLES=4, mem_ready_i held low → mem_req_o high for 4 cycles, then core_err_o pulses 1 cycle and core_rd_o=0.
- rst_i asserted mid-BUSY → mem_req_o and stall drop immediately, state IDLE; a new LW afterwards completes normally.
- With LSU_MISALIGN_CHECK_EN defined: LW addr 0x102 → no mem_req_o, core_err_o=1 in the cycle after the request. Without the macro: LW addr 0x102 → mem_addr_o=0x100, normal completion.
